// File: rtl/fetch_stall_controller.sv
// Fetch-stage sequencer: PC/IF-ID/ID-EX stall controls, I-cache miss refill FSM
// and saturating miss/stall performance counters.
module fetch_stall_controller #(
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                           clock,
    input  logic                           resetN,
    input  logic [31:0]                    fetchPc,
    input  logic                           cacheHit,
    input  logic                           loadUseHazard,
    input  logic                           branchTaken,
    output logic                           memReq,
    output logic [31:0]                    memAddr,
    input  logic                           memReady,
    input  logic [31:0]                    memData,
    output logic                           fillValid,
    output logic [$clog2(BLOCK_WORDS)-1:0] fillWord,
    output logic [31:0]                    fillData,
    output logic                           pcWrite,
    output logic                           ifidWrite,
    output logic                           ifidFlush,
    output logic                           idexBubble,
    output logic [CNT_W-1:0]               missCount,
    output logic [CNT_W-1:0]               stallCycles
);

    localparam int unsigned WordW = $clog2(BLOCK_WORDS);
    localparam int unsigned OffW  = WordW + 2;

    typedef enum logic [1:0] {StRun, StFill, StDone} state_e;

    state_e             r_state;
    logic [WordW-1:0]   r_beat;
    logic [31:0]        r_block_addr;
    logic               r_mem_req;
    logic [CNT_W-1:0]   r_miss_count;
    logic [CNT_W-1:0]   r_stall_cycles;

    logic w_beat_accept;
    logic w_last_beat;
    logic w_missing;
    logic w_pc_write;

    assign w_beat_accept = r_mem_req & memReady;
    assign w_last_beat   = (r_beat == WordW'(BLOCK_WORDS - 1));
    // Outside RUN the cache is still being refilled, so the fetched word is never usable.
    assign w_missing     = (r_state != StRun) || !cacheHit;

    always_comb begin
        w_pc_write = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        if (loadUseHazard) begin
            w_pc_write = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
        end else if (branchTaken) begin
            ifidFlush  = 1'b1;
        end else if (w_missing) begin
            w_pc_write = 1'b0;
            ifidFlush  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state        <= StRun;
            r_beat         <= '0;
            r_block_addr   <= '0;
            r_mem_req      <= 1'b0;
            r_miss_count   <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (!w_pc_write && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            case (r_state)
                StRun: begin
                    if (!cacheHit) begin
                        r_state      <= StFill;
                        r_block_addr <= {fetchPc[31:OffW], {OffW{1'b0}}};
                        r_beat       <= '0;
                        r_mem_req    <= 1'b1;
                        if (r_miss_count != {CNT_W{1'b1}}) begin
                            r_miss_count <= r_miss_count + 1'b1;
                        end
                    end
                end
                StFill: begin
                    // A taken branch does not cancel the refill; the block stays valid.
                    if (w_beat_accept) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last_beat) begin
                            r_state   <= StDone;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    r_state <= StRun;
                end
                default: begin
                    r_state <= StRun;
                end
            endcase
        end
    end

    assign memReq      = r_mem_req;
    assign memAddr     = r_block_addr + {{(30 - WordW){1'b0}}, r_beat, 2'b00};
    assign fillValid   = w_beat_accept;
    assign fillWord    = r_beat;
    assign fillData    = memData;
    assign pcWrite     = w_pc_write;
    assign missCount   = r_miss_count;
    assign stallCycles = r_stall_cycles;

endmodule

// File: tb/tb_fetch_stall_controller.sv
// Directed bench for fetch_stall_controller: refill sequencing, stall priority,
// async reset mid-refill and counter saturation.
module tb_fetch_stall_controller;

    logic        clock;
    logic        resetN;
    logic [31:0] fetchPc;
    logic        cacheHit;
    logic        loadUseHazard;
    logic        branchTaken;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memReady;
    logic [31:0] memData;
    logic        fillValid;
    logic [1:0]  fillWord;
    logic [31:0] fillData;
    logic        pcWrite;
    logic        ifidWrite;
    logic        ifidFlush;
    logic        idexBubble;
    logic [15:0] missCount;
    logic [15:0] stallCycles;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stall_controller #(
        .BLOCK_WORDS (4),
        .CNT_W       (16)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .fetchPc       (fetchPc),
        .cacheHit      (cacheHit),
        .loadUseHazard (loadUseHazard),
        .branchTaken   (branchTaken),
        .memReq        (memReq),
        .memAddr       (memAddr),
        .memReady      (memReady),
        .memData       (memData),
        .fillValid     (fillValid),
        .fillWord      (fillWord),
        .fillData      (fillData),
        .pcWrite       (pcWrite),
        .ifidWrite     (ifidWrite),
        .ifidFlush     (ifidFlush),
        .idexBubble    (idexBubble),
        .missCount     (missCount),
        .stallCycles   (stallCycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks happen 1 unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [9:0] ready_pat;
        int         exp_beat;
        int         pulses;

        resetN        = 1'b0;
        fetchPc       = 32'h0000_1000;
        cacheHit      = 1'b1;
        loadUseHazard = 1'b0;
        branchTaken   = 1'b0;
        memReady      = 1'b0;
        memData       = 32'h0;

        // Reset state
        step();
        step();
        settle();
        check("rst_memReq", {31'd0, memReq}, 32'd0);
        check("rst_memAddr", memAddr, 32'h0);
        check("rst_missCount", {16'd0, missCount}, 32'd0);
        check("rst_stallCycles", {16'd0, stallCycles}, 32'd0);
        check("rst_pcWrite", {31'd0, pcWrite}, 32'd1);
        check("rst_ifidFlush", {31'd0, ifidFlush}, 32'd0);
        resetN = 1'b1;
        step();

        // Miss with memReady held high
        fetchPc  = 32'h0000_104C;
        cacheHit = 1'b0;
        memReady = 1'b1;
        settle();
        check("miss_t_pcWrite", {31'd0, pcWrite}, 32'd0);
        check("miss_t_ifidFlush", {31'd0, ifidFlush}, 32'd1);
        check("miss_t_memReq", {31'd0, memReq}, 32'd0);
        step();
        cacheHit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            memData = 32'hA000_0000 + 32'(i);
            settle();
            check("miss_memReq", {31'd0, memReq}, 32'd1);
            check("miss_memAddr", memAddr, 32'h0000_1040 + 32'(4 * i));
            check("miss_fillValid", {31'd0, fillValid}, 32'd1);
            check("miss_fillWord", {30'd0, fillWord}, 32'(i));
            check("miss_fillData", fillData, 32'hA000_0000 + 32'(i));
            check("miss_pcWrite", {31'd0, pcWrite}, 32'd0);
            step();
        end
        settle();
        check("miss_done_memReq", {31'd0, memReq}, 32'd0);
        check("miss_done_pcWrite", {31'd0, pcWrite}, 32'd0);
        check("miss_done_fillValid", {31'd0, fillValid}, 32'd0);
        step();
        settle();
        check("miss_run_pcWrite", {31'd0, pcWrite}, 32'd1);
        check("miss_run_ifidFlush", {31'd0, ifidFlush}, 32'd0);
        check("miss_stallCycles", {16'd0, stallCycles}, 32'd6);
        check("miss_missCount", {16'd0, missCount}, 32'd1);

        // Miss with memReady toggling 1,0,0,1,...
        fetchPc   = 32'h0000_2008;
        cacheHit  = 1'b0;
        memReady  = 1'b0;
        step();
        cacheHit  = 1'b1;
        ready_pat = 10'b10_0100_1001;
        exp_beat  = 0;
        pulses    = 0;
        for (int i = 0; i < 10; i++) begin
            memReady = ready_pat[i];
            settle();
            check("tog_memReq", {31'd0, memReq}, 32'd1);
            check("tog_memAddr", memAddr, 32'h0000_2000 + 32'(4 * exp_beat));
            check("tog_fillValid", {31'd0, fillValid}, {31'd0, ready_pat[i]});
            if (fillValid) pulses++;
            if (ready_pat[i]) begin
                check("tog_fillWord", {30'd0, fillWord}, 32'(exp_beat));
                exp_beat++;
            end
            step();
        end
        memReady = 1'b1;
        settle();
        check("tog_done_memReq", {31'd0, memReq}, 32'd0);
        check("tog_done_fillValid", {31'd0, fillValid}, 32'd0);
        step();
        settle();
        check("tog_pulses", 32'(pulses), 32'd4);
        check("tog_stallCycles", {16'd0, stallCycles}, 32'd18);
        check("tog_missCount", {16'd0, missCount}, 32'd2);

        // Load-use hazard overrides taken branch
        loadUseHazard = 1'b1;
        branchTaken   = 1'b1;
        settle();
        check("haz_pcWrite", {31'd0, pcWrite}, 32'd0);
        check("haz_ifidWrite", {31'd0, ifidWrite}, 32'd0);
        check("haz_idexBubble", {31'd0, idexBubble}, 32'd1);
        check("haz_ifidFlush", {31'd0, ifidFlush}, 32'd0);
        step();
        loadUseHazard = 1'b0;
        settle();
        check("br_pcWrite", {31'd0, pcWrite}, 32'd1);
        check("br_ifidWrite", {31'd0, ifidWrite}, 32'd1);
        check("br_ifidFlush", {31'd0, ifidFlush}, 32'd1);
        check("br_idexBubble", {31'd0, idexBubble}, 32'd0);
        step();
        branchTaken = 1'b0;
        settle();
        check("br_stallCycles", {16'd0, stallCycles}, 32'd19);

        // Taken branch during refill beat 1
        fetchPc  = 32'h0000_3000;
        cacheHit = 1'b0;
        step();
        cacheHit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            branchTaken = (i == 1);
            settle();
            check("fbr_fillValid", {31'd0, fillValid}, 32'd1);
            check("fbr_fillWord", {30'd0, fillWord}, 32'(i));
            check("fbr_memAddr", memAddr, 32'h0000_3000 + 32'(4 * i));
            check("fbr_pcWrite", {31'd0, pcWrite}, {31'd0, (i == 1)});
            check("fbr_ifidFlush", {31'd0, ifidFlush}, 32'd1);
            step();
        end
        branchTaken = 1'b0;
        settle();
        check("fbr_done_memReq", {31'd0, memReq}, 32'd0);
        step();
        fetchPc = 32'h0000_4000;
        settle();
        check("fbr_run_pcWrite", {31'd0, pcWrite}, 32'd1);
        check("fbr_run_ifidFlush", {31'd0, ifidFlush}, 32'd0);
        check("fbr_stallCycles", {16'd0, stallCycles}, 32'd24);
        check("fbr_missCount", {16'd0, missCount}, 32'd3);

        // Async reset during refill beat 2
        fetchPc  = 32'h0000_5000;
        cacheHit = 1'b0;
        step();
        cacheHit = 1'b1;
        step();
        step();
        settle();
        check("ar_beat2_fillWord", {30'd0, fillWord}, 32'd2);
        check("ar_beat2_memReq", {31'd0, memReq}, 32'd1);
        resetN = 1'b0;
        settle();
        check("ar_memReq", {31'd0, memReq}, 32'd0);
        check("ar_fillValid", {31'd0, fillValid}, 32'd0);
        check("ar_memAddr", memAddr, 32'h0);
        check("ar_missCount", {16'd0, missCount}, 32'd0);
        check("ar_stallCycles", {16'd0, stallCycles}, 32'd0);
        check("ar_pcWrite", {31'd0, pcWrite}, 32'd1);
        step();
        resetN   = 1'b1;
        memReady = 1'b0;
        step();

        // Stall counter saturation
        loadUseHazard = 1'b1;
        repeat (65534) @(posedge clock);
        #1;
        check("sat_fffe", {16'd0, stallCycles}, 32'h0000_FFFE);
        repeat (3) @(posedge clock);
        #1;
        check("sat_ffff", {16'd0, stallCycles}, 32'h0000_FFFF);
        loadUseHazard = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
